q_add8_seq: RTL and testbench

- Sequencer on the far side of the 8-bit quantized element-wise adder's streaming interface.
- Fetches operand pairs from two operand buffers and issues them on the adder's enable/data inputs.
- Collects the adder's enable-qualified results and writes them back to a result buffer.
- Signals completion once every result has landed. Sits between the NPU layer controller and the adder datapath.

---
 rtl/q_add8_seq_pkg.sv | 19 +
 rtl/q_add8_seq_wr.sv | 60 ++++++
 rtl/q_add8_seq.sv | 133 +++++++++++++
 tb/tb_q_add8_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/q_add8_seq_pkg.sv
// Shared FSM encoding and defaults for the 8-bit quantized adder sequencer.
// Optional build macro Q_ADD_SEQ_STATS_EN adds RES_MIN/RES_MAX result statistics outputs.
package q_add8_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } seq_state_t;

    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_ADD_LAT = 8;

    // Statistics clear values: min starts high, max starts low, so the first write sets both.
    localparam logic [7:0] STAT_MIN_INIT = 8'hFF;
    localparam logic [7:0] STAT_MAX_INIT = 8'h00;

endpackage

// File: rtl/q_add8_seq_wr.sv
// Result write-back path: write counter, result address generation and optional min/max stats.
// Stats logic exists only when Q_ADD_SEQ_STATS_EN is defined.
module q_add8_seq_wr
    import q_add8_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET_X,
    input  logic              clr,
    input  logic              busy,
    input  logic [ADDR_W:0]   len,
    input  logic [ADDR_W-1:0] c_base,
    input  logic              add_out_en,
    input  logic [7:0]        add_c,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_done
`ifdef Q_ADD_SEQ_STATS_EN
    ,
    output logic [7:0]        res_min,
    output logic [7:0]        res_max
`endif
);

    logic [ADDR_W:0] wr_cnt;
    logic [ADDR_W:0] wr_cnt_nxt;

    // Results arriving outside an operation or past the element count are dropped.
    always_comb begin
        wr_en      = add_out_en && busy && (wr_cnt < len);
        wr_addr    = wr_en ? (c_base + wr_cnt[ADDR_W-1:0]) : '0;
        wr_data    = wr_en ? add_c : '0;
        wr_cnt_nxt = wr_cnt + {{ADDR_W{1'b0}}, wr_en};
        // Look-ahead so DONE follows the final write by exactly one cycle.
        wr_done    = (wr_cnt_nxt == len);
    end

    always_ff @(posedge CLK) begin
        if (RESET_X || clr) begin
            wr_cnt <= '0;
        end else begin
            wr_cnt <= wr_cnt_nxt;
        end
    end

`ifdef Q_ADD_SEQ_STATS_EN
    always_ff @(posedge CLK) begin
        if (RESET_X || clr) begin
            res_min <= STAT_MIN_INIT;
            res_max <= STAT_MAX_INIT;
        end else if (wr_en) begin
            if (add_c < res_min) res_min <= add_c;
            if (add_c > res_max) res_max <= add_c;
        end
    end
`endif

endmodule

// File: rtl/q_add8_seq.sv
// Sequencer feeding the 8-bit quantized element-wise adder from operand buffers and writing results back.
// Optional build macro Q_ADD_SEQ_STATS_EN adds RES_MIN/RES_MAX ports.
module q_add8_seq
    import q_add8_seq_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int ADD_LAT = DEF_ADD_LAT
) (
    input  logic              CLK,
    input  logic              RESET_X,
    input  logic              START,
    input  logic [ADDR_W:0]   LEN,
    input  logic [ADDR_W-1:0] A_BASE,
    input  logic [ADDR_W-1:0] B_BASE,
    input  logic [ADDR_W-1:0] C_BASE,
    output logic              BUSY,
    output logic              DONE,
    output logic              A_RD_EN,
    output logic [ADDR_W-1:0] A_RD_ADDR,
    input  logic [7:0]        A_RD_DATA,
    output logic              B_RD_EN,
    output logic [ADDR_W-1:0] B_RD_ADDR,
    input  logic [7:0]        B_RD_DATA,
    output logic              ADD_EN,
    output logic [7:0]        ADD_A,
    output logic [7:0]        ADD_B,
    input  logic              ADD_OUT_EN,
    input  logic [7:0]        ADD_C,
    output logic              C_WR_EN,
    output logic [ADDR_W-1:0] C_WR_ADDR,
    output logic [7:0]        C_WR_DATA
`ifdef Q_ADD_SEQ_STATS_EN
    ,
    output logic [7:0]        RES_MIN,
    output logic [7:0]        RES_MAX
`endif
);

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    // Adder latency only sizes the drain window seen by the environment; reject nonsense values.
    if (ADD_LAT < 1) begin : g_lat_chk
        $error("q_add8_seq: ADD_LAT must be at least 1");
    end

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   rd_cnt;
    logic [ADDR_W-1:0] a_base_q;
    logic [ADDR_W-1:0] b_base_q;
    logic [ADDR_W-1:0] c_base_q;
    logic              add_en_q;
    logic              start_acc;
    logic              rd_en;
    logic              busy;
    logic              wr_done;

    assign start_acc = (state == IDLE) && START;
    assign rd_en     = (state == ISSUE);
    assign busy      = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RESET_X) begin
            state    <= IDLE;
            len_q    <= '0;
            rd_cnt   <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            c_base_q <= '0;
            add_en_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            add_en_q <= rd_en;
            if (start_acc) begin
                len_q    <= LEN;
                a_base_q <= A_BASE;
                b_base_q <= B_BASE;
                c_base_q <= C_BASE;
                rd_cnt   <= '0;
            end else if (rd_en) begin
                rd_cnt <= rd_cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = (LEN == '0) ? FIN : ISSUE;
            ISSUE:   if (rd_cnt == len_q - CNT_ONE) state_nxt = DRAIN;
            DRAIN:   if (wr_done) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Buffer read data lands the cycle after the strobe, which is when ADD_EN is high.
    always_comb begin
        BUSY      = busy;
        DONE      = (state == FIN);
        A_RD_EN   = rd_en;
        B_RD_EN   = rd_en;
        A_RD_ADDR = rd_en ? (a_base_q + rd_cnt[ADDR_W-1:0]) : '0;
        B_RD_ADDR = rd_en ? (b_base_q + rd_cnt[ADDR_W-1:0]) : '0;
        ADD_EN    = add_en_q;
        ADD_A     = add_en_q ? A_RD_DATA : '0;
        ADD_B     = add_en_q ? B_RD_DATA : '0;
    end

    q_add8_seq_wr #(
        .ADDR_W (ADDR_W)
    ) u_wr (
        .CLK        (CLK),
        .RESET_X    (RESET_X),
        .clr        (start_acc),
        .busy       (busy),
        .len        (len_q),
        .c_base     (c_base_q),
        .add_out_en (ADD_OUT_EN),
        .add_c      (ADD_C),
        .wr_en      (C_WR_EN),
        .wr_addr    (C_WR_ADDR),
        .wr_data    (C_WR_DATA),
        .wr_done    (wr_done)
`ifdef Q_ADD_SEQ_STATS_EN
        ,
        .res_min    (RES_MIN),
        .res_max    (RES_MAX)
`endif
    );

endmodule

// File: tb/tb_q_add8_seq.sv
// Directed bench for q_add8_seq with buffer models and a fixed-latency stub adder.
module tb_q_add8_seq;

    localparam int ADDR_W  = 12;
    localparam int ADD_LAT = 8;

    logic              CLK = 1'b0;
    logic              RESET_X = 1'b1;
    logic              START = 1'b0;
    logic [ADDR_W:0]   LEN = '0;
    logic [ADDR_W-1:0] A_BASE = '0, B_BASE = '0, C_BASE = '0;
    logic              BUSY, DONE, A_RD_EN, B_RD_EN, ADD_EN, ADD_OUT_EN, C_WR_EN;
    logic [ADDR_W-1:0] A_RD_ADDR, B_RD_ADDR, C_WR_ADDR;
    logic [7:0]        A_RD_DATA = '0, B_RD_DATA = '0;
    logic [7:0]        ADD_A, ADD_B, ADD_C, C_WR_DATA;
`ifdef Q_ADD_SEQ_STATS_EN
    logic [7:0]        RES_MIN, RES_MAX;
`endif

    q_add8_seq #(.ADDR_W(ADDR_W), .ADD_LAT(ADD_LAT)) dut (
        .CLK(CLK), .RESET_X(RESET_X), .START(START), .LEN(LEN),
        .A_BASE(A_BASE), .B_BASE(B_BASE), .C_BASE(C_BASE),
        .BUSY(BUSY), .DONE(DONE),
        .A_RD_EN(A_RD_EN), .A_RD_ADDR(A_RD_ADDR), .A_RD_DATA(A_RD_DATA),
        .B_RD_EN(B_RD_EN), .B_RD_ADDR(B_RD_ADDR), .B_RD_DATA(B_RD_DATA),
        .ADD_EN(ADD_EN), .ADD_A(ADD_A), .ADD_B(ADD_B),
        .ADD_OUT_EN(ADD_OUT_EN), .ADD_C(ADD_C),
        .C_WR_EN(C_WR_EN), .C_WR_ADDR(C_WR_ADDR), .C_WR_DATA(C_WR_DATA)
`ifdef Q_ADD_SEQ_STATS_EN
        , .RES_MIN(RES_MIN), .RES_MAX(RES_MAX)
`endif
    );

    always #5 CLK = ~CLK;

    // Operand buffers with one-cycle synchronous read.
    logic [7:0] mem_a [4096];
    logic [7:0] mem_b [4096];
    always @(posedge CLK) begin
        if (A_RD_EN) A_RD_DATA <= mem_a[A_RD_ADDR];
        if (B_RD_EN) B_RD_DATA <= mem_b[B_RD_ADDR];
    end

    // Stub adder: ADD_EN in cycle n gives ADD_OUT_EN in cycle n+ADD_LAT.
    logic [ADD_LAT-1:0] pen = '0;
    logic [7:0]         pc [ADD_LAT];
    always @(posedge CLK) begin
        pen   <= {pen[ADD_LAT-2:0], ADD_EN};
        pc[0] <= ADD_A + ADD_B;
        for (int k = 1; k < ADD_LAT; k++) pc[k] <= pc[k-1];
    end
    assign ADD_OUT_EN = pen[ADD_LAT-1];
    assign ADD_C      = pc[ADD_LAT-1];

    int vectors = 0, miscompares = 0;

    // Per-operation observations, cycle 1 = first cycle after the accepted START edge.
    int done_cyc, done_cnt, busy_first, busy_last, busy_cnt, rd_n, wr_n, wr_first, wr_last, idle_nz;
    logic snap;
    logic [ADDR_W-1:0] rd_addr_q[$], b_addr_q[$], wr_addr_q[$];
    logic [7:0]        wr_data_q[$];

    task automatic kick(input logic [ADDR_W:0] len, input logic [ADDR_W-1:0] ab, bb, cb);
        @(negedge CLK);
        START = 1'b1; LEN = len; A_BASE = ab; B_BASE = bb; C_BASE = cb;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic observe(input int ncyc, input int start_at, input logic [ADDR_W:0] start_len,
                           input int rst_at);
        done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1; busy_cnt = 0;
        rd_n = 0; wr_n = 0; wr_first = -1; wr_last = -1; idle_nz = 0; snap = 1'b0;
        rd_addr_q.delete(); b_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        for (int n = 1; n <= ncyc; n++) begin
            if (n > 1) @(negedge CLK);
            START = (n == start_at);
            if (n == start_at) begin
                LEN = start_len; A_BASE = 12'h555; B_BASE = 12'h666; C_BASE = 12'h777;
            end
            RESET_X = (n == rst_at);
            if (n == rst_at + 1)
                snap = (|{BUSY, DONE, A_RD_EN, B_RD_EN, ADD_EN, C_WR_EN}) ||
                       (|{A_RD_ADDR, B_RD_ADDR, C_WR_ADDR, ADD_A, ADD_B, C_WR_DATA});
            if (BUSY) begin
                if (busy_first < 0) busy_first = n;
                busy_last = n; busy_cnt++;
            end
            if (DONE) begin
                if (done_cyc < 0) done_cyc = n;
                done_cnt++;
            end
            if (A_RD_EN) begin rd_n++; rd_addr_q.push_back(A_RD_ADDR); end
            if (B_RD_EN) b_addr_q.push_back(B_RD_ADDR);
            if (!ADD_EN && (ADD_A != 8'h00 || ADD_B != 8'h00)) idle_nz++;
            if (C_WR_EN) begin
                if (wr_first < 0) wr_first = n;
                wr_last = n; wr_n++;
                wr_addr_q.push_back(C_WR_ADDR); wr_data_q.push_back(C_WR_DATA);
            end
        end
        START = 1'b0; RESET_X = 1'b0;
    endtask

    task automatic test_reset();
        RESET_X = 1'b1;
        repeat (3) @(negedge CLK);
        vectors++;
        if ({BUSY, DONE, A_RD_EN, B_RD_EN, ADD_EN, C_WR_EN} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 000000", {BUSY, DONE, A_RD_EN, B_RD_EN, ADD_EN, C_WR_EN});
        end
        vectors++;
        if ({A_RD_ADDR, B_RD_ADDR, C_WR_ADDR, ADD_A, ADD_B, C_WR_DATA} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: addr/data outputs not all zero (A_RD_ADDR=%0d C_WR_ADDR=%0d)", A_RD_ADDR, C_WR_ADDR);
        end
`ifdef Q_ADD_SEQ_STATS_EN
        vectors++;
        if ({RES_MIN, RES_MAX} !== 16'hFF00) begin
            miscompares++;
            $display("FAIL reset_stats: got min=%0h max=%0h want ff/00", RES_MIN, RES_MAX);
        end
`endif
        RESET_X = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'd11; exp_d[1] = 8'd22; exp_d[2] = 8'd33; exp_d[3] = 8'd44;
        for (int i = 0; i < 4; i++) begin
            mem_a[100+i] = 8'(i + 1);
            mem_b[200+i] = 8'(10 * (i + 1));
        end
        kick(13'd4, 12'd100, 12'd200, 12'd300);
        observe(20, -1, '0, -5);
        vectors++; if (done_cyc !== 14) begin miscompares++; $display("FAIL basic_done_cyc: got %0d want 14", done_cyc); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
        vectors++; if (busy_first !== 1 || busy_last !== 14 || busy_cnt !== 14) begin
            miscompares++; $display("FAIL basic_busy: got first=%0d last=%0d cnt=%0d want 1/14/14", busy_first, busy_last, busy_cnt); end
        vectors++; if (rd_n !== 4) begin miscompares++; $display("FAIL basic_reads: got %0d want 4", rd_n); end
        vectors++; if (wr_first !== 10 || wr_last !== 13) begin
            miscompares++; $display("FAIL basic_wr_window: got %0d..%0d want 10..13", wr_first, wr_last); end
        vectors++; if (idle_nz !== 0) begin miscompares++; $display("FAIL basic_add_idle_zero: got %0d nonzero cycles want 0", idle_nz); end
        vectors++; if (wr_n !== 4) begin miscompares++; $display("FAIL basic_writes: got %0d want 4", wr_n); end
        for (int i = 0; i < 4 && i < wr_n; i++) begin
            vectors++;
            if (wr_addr_q[i] !== 12'(300 + i) || wr_data_q[i] !== exp_d[i]) begin
                miscompares++;
                $display("FAIL basic_wr%0d: got addr=%0d data=%0d want addr=%0d data=%0d", i, wr_addr_q[i], wr_data_q[i], 300 + i, exp_d[i]);
            end
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_len0();
        kick(13'd0, 12'd1, 12'd2, 12'd3);
        observe(12, -1, '0, -5);
        vectors++; if (done_cyc !== 1 || done_cnt !== 1) begin
            miscompares++; $display("FAIL len0_done: got cyc=%0d cnt=%0d want 1/1", done_cyc, done_cnt); end
        vectors++; if (busy_first !== 1 || busy_cnt !== 1) begin
            miscompares++; $display("FAIL len0_busy: got first=%0d cnt=%0d want 1/1", busy_first, busy_cnt); end
        vectors++; if (rd_n !== 0 || wr_n !== 0) begin
            miscompares++; $display("FAIL len0_strobes: got rd=%0d wr=%0d want 0/0", rd_n, wr_n); end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] exp_a [4];
        logic [ADDR_W-1:0] exp_b [4];
        logic [7:0]        exp_d [4];
        exp_a[0] = 12'd4094; exp_a[1] = 12'd4095; exp_a[2] = 12'd0; exp_a[3] = 12'd1;
        exp_b[0] = 12'd4095; exp_b[1] = 12'd0;    exp_b[2] = 12'd1; exp_b[3] = 12'd2;
        exp_d[0] = 8'd55;    exp_d[1] = 8'd66;    exp_d[2] = 8'd77; exp_d[3] = 8'd88;
        for (int i = 0; i < 4; i++) begin
            mem_a[exp_a[i]] = 8'(5 + i);
            mem_b[exp_b[i]] = 8'(50 + 10 * i);
        end
        kick(13'd4, 12'd4094, 12'd4095, 12'd4094);
        observe(20, -1, '0, -5);
        vectors++; if (rd_addr_q.size() !== 4 || wr_n !== 4) begin
            miscompares++; $display("FAIL wrap_counts: got rd=%0d wr=%0d want 4/4", rd_addr_q.size(), wr_n); end
        for (int i = 0; i < 4 && i < rd_addr_q.size() && i < wr_n; i++) begin
            vectors++;
            if (rd_addr_q[i] !== exp_a[i] || b_addr_q[i] !== exp_b[i] || wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== exp_d[i]) begin
                miscompares++;
                $display("FAIL wrap_%0d: got a=%0d b=%0d c=%0d d=%0d want a=%0d b=%0d c=%0d d=%0d", i,
                         rd_addr_q[i], b_addr_q[i], wr_addr_q[i], wr_data_q[i], exp_a[i], exp_b[i], exp_a[i], exp_d[i]);
            end
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_start_in_drain();
        kick(13'd4, 12'd100, 12'd200, 12'd600);
        observe(24, 7, 13'd9, -5);
        vectors++; if (wr_n !== 4) begin miscompares++; $display("FAIL drain_start_writes: got %0d want 4", wr_n); end
        vectors++; if (done_cnt !== 1 || done_cyc !== 14) begin
            miscompares++; $display("FAIL drain_start_done: got cnt=%0d cyc=%0d want 1/14", done_cnt, done_cyc); end
        vectors++; if (rd_n !== 4) begin miscompares++; $display("FAIL drain_start_reads: got %0d want 4", rd_n); end
        vectors++; if (wr_n > 3 && (wr_addr_q[0] !== 12'd600 || wr_addr_q[3] !== 12'd603 || wr_data_q[3] !== 8'd44)) begin
            miscompares++; $display("FAIL drain_start_addr: got first=%0d last=%0d d=%0d want 600/603/44", wr_addr_q[0], wr_addr_q[3], wr_data_q[3]); end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        kick(13'd8, 12'd100, 12'd200, 12'd900);
        observe(20, -1, '0, 4);
        vectors++; if (snap !== 1'b0) begin miscompares++; $display("FAIL midreset_outputs: got nonzero outputs after reset want all 0"); end
        vectors++; if (busy_last !== 4 || busy_cnt !== 4) begin
            miscompares++; $display("FAIL midreset_busy: got last=%0d cnt=%0d want 4/4", busy_last, busy_cnt); end
        vectors++; if (wr_n !== 0 || done_cnt !== 0) begin
            miscompares++; $display("FAIL midreset_late: got wr=%0d done=%0d want 0/0", wr_n, done_cnt); end
        repeat (2) @(negedge CLK);
    endtask

`ifdef Q_ADD_SEQ_STATS_EN
    task automatic test_stats();
        mem_a[10] = 8'd3; mem_a[11] = 8'd100; mem_a[12] = 8'd1;
        mem_b[20] = 8'd4; mem_b[21] = 8'd100; mem_b[22] = 8'd2;
        kick(13'd3, 12'd10, 12'd20, 12'd50);
        observe(17, -1, '0, -5);
        vectors++; if (RES_MIN !== 8'd3 || RES_MAX !== 8'd200) begin
            miscompares++; $display("FAIL stats_minmax: got min=%0d max=%0d want 3/200", RES_MIN, RES_MAX); end
        kick(13'd0, 12'd0, 12'd0, 12'd0);
        vectors++; if (RES_MIN !== 8'hFF || RES_MAX !== 8'h00) begin
            miscompares++; $display("FAIL stats_clear: got min=%0h max=%0h want ff/00", RES_MIN, RES_MAX); end
        observe(6, -1, '0, -5);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        test_reset();
        test_basic();
        test_len0();
        test_wrap();
        test_start_in_drain();
        test_reset_mid();
`ifdef Q_ADD_SEQ_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
